// File: rtl/melody_sequencer.sv
// melody_sequencer
//   Plays the fixed beep melody by stepping through a 21-entry note/duration
//   ROM. Each step is one LOAD cycle followed by dur*TICK_DIV PLAY cycles.
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : begin playback at step 0 (IDLE only)
//   stop        : abort playback from any busy state, no done pulse
//   loop_en     : sampled at the end of the last step; 1 restarts at step 0
//   step_idx    : current ROM step (tone-mux select)
//   note_sel    : tone code of the current step, 13 = silence
//   tone_en     : high while playing a non-silent note
//   busy        : high in LOAD/PLAY/FINISH
//   done        : one-cycle pulse on normal completion
module melody_sequencer #(
  parameter int TICK_DIV  = 5_000_000,
  parameter int NUM_STEPS = 21
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       loop_en,
  output logic [7:0] step_idx,
  output logic [3:0] note_sel,
  output logic       tone_en,
  output logic       busy,
  output logic       done
);

  localparam int              CW        = $clog2(TICK_DIV);
  localparam logic [CW-1:0]   TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [7:0]      LAST_STEP = 8'(NUM_STEPS - 1);
  localparam logic [3:0]      SILENCE   = 4'd13;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, FINISH} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    dur_q, dur_d;
  logic [7:0]    step_q, step_d;
  logic [3:0]    note_q, note_d;
  logic          tone_q, tone_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          tick;
  logic [3:0]    rom_n;

  // Entries past the melody (NUM_STEPS > 21) play as 1-unit silence.
  function automatic logic [3:0] rom_note(input logic [7:0] i);
    case (i)
      8'd1, 8'd2, 8'd3, 8'd6, 8'd7, 8'd8:         rom_note = 4'd4;
      8'd11, 8'd12, 8'd17, 8'd18, 8'd19, 8'd20:   rom_note = 4'd6;
      8'd13:                                      rom_note = 4'd5;
      8'd14:                                      rom_note = 4'd3;
      8'd15:                                      rom_note = 4'd12;
      8'd16:                                      rom_note = 4'd2;
      default:                                    rom_note = SILENCE;
    endcase
  endfunction

  function automatic logic [2:0] rom_dur(input logic [7:0] i);
    rom_dur = (i == 8'd20) ? 3'd4 : 3'd1;
  endfunction

  assign rom_n = rom_note(step_q);
  assign tick  = (state_q == PLAY) && (cnt_q == TICK_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    dur_d   = dur_q;
    step_d  = step_q;
    note_d  = note_q;
    tone_d  = tone_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = LOAD;
          step_d  = 8'd0;
          busy_d  = 1'b1;
        end
      end
      LOAD: begin
        note_d  = rom_n;
        dur_d   = rom_dur(step_q);
        tone_d  = (rom_n != SILENCE);
        state_d = PLAY;
      end
      PLAY: begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
        if (tick) begin
          if (dur_q == 3'd1) begin
            tone_d = 1'b0;
            if (step_q < LAST_STEP) begin
              step_d  = step_q + 8'd1;
              state_d = LOAD;
            end else if (loop_en) begin
              step_d  = 8'd0;
              state_d = LOAD;
            end else begin
              note_d  = SILENCE;
              done_d  = 1'b1;
              state_d = FINISH;
            end
          end else begin
            dur_d = dur_q - 3'd1;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
        step_d  = 8'd0;
        note_d  = SILENCE;
        tone_d  = 1'b0;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over tick, loop and advance; no done pulse.
    if (stop && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      dur_d   = 3'd0;
      step_d  = 8'd0;
      note_d  = SILENCE;
      tone_d  = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dur_q   <= 3'd0;
      step_q  <= 8'd0;
      note_q  <= SILENCE;
      tone_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dur_q   <= dur_d;
      step_q  <= step_d;
      note_q  <= note_d;
      tone_q  <= tone_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign step_idx = step_q;
  assign note_sel = note_q;
  assign tone_en  = tone_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
module tb_melody_sequencer;
  logic       clk = 1'b0;
  logic       rst_n, start, stop, loop_en;
  logic [7:0] step_idx;
  logic [3:0] note_sel;
  logic       tone_en, busy, done;

  int tests = 0;
  int errors = 0;
  int t;
  int note_tab [21] = '{13,4,4,4,13,13,4,4,4,13,13,6,6,5,3,12,2,6,6,6,6};

  always #5 clk = ~clk;

  melody_sequencer #(.TICK_DIV(4), .NUM_STEPS(21)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
    .step_idx(step_idx), .note_sel(note_sel), .tone_en(tone_en),
    .busy(busy), .done(done)
  );

  task automatic adv();
    @(negedge clk);
    t++;
  endtask

  // After return, t=0 is the cycle in LOAD of step 0.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
  endtask

  task automatic run_to(input int target);
    while (t < target) adv();
  endtask

  task automatic chk_idle(input string nm);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || tone_en !== 1'b0 ||
        step_idx !== 8'd0 || note_sel !== 4'd13) begin
      errors++;
      $display("FAIL %s: busy=%b done=%b tone=%b step=%0d note=%0d, required 0 0 0 0 13",
               nm, busy, done, tone_en, step_idx, note_sel);
    end
  endtask

  // Checks one observation within a single pass; t relative to LOAD of step 0.
  task automatic chk_pass(input string nm, input int tt);
    int s;
    logic ld;
    logic exp_tone;
    s  = (tt < 100) ? tt / 5 : 20;
    ld = (tt < 100) ? (tt % 5 == 0) : (tt == 100);
    exp_tone = ld ? 1'b0 : (note_tab[s] != 13);
    tests++;
    if (step_idx !== 8'(s) || tone_en !== exp_tone || busy !== 1'b1 || done !== 1'b0 ||
        (!ld && note_sel !== 4'(note_tab[s]))) begin
      errors++;
      $display("FAIL %s t=%0d: step=%0d tone=%b busy=%b done=%b note=%0d, required step=%0d tone=%b busy=1 done=0 note=%0d",
               nm, tt, step_idx, tone_en, busy, done, note_sel, s, exp_tone, note_tab[s]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("after_reset_release");
  endtask

  task automatic test_first_step();
    pulse_start();
    tests++;
    if (busy !== 1'b1 || tone_en !== 1'b0) begin
      errors++;
      $display("FAIL first_load: busy=%b tone=%b, required 1 0", busy, tone_en);
    end
    adv();
    tests++;
    if (step_idx !== 8'd0 || note_sel !== 4'd13 || tone_en !== 1'b0) begin
      errors++;
      $display("FAIL step0_play: step=%0d note=%0d tone=%b, required 0 13 0", step_idx, note_sel, tone_en);
    end
    run_to(4);
    tests++;
    if (step_idx !== 8'd0) begin
      errors++;
      $display("FAIL step0_len: step=%0d at t=4, required 0", step_idx);
    end
    adv();
    tests++;
    if (step_idx !== 8'd1 || tone_en !== 1'b0) begin
      errors++;
      $display("FAIL step1_load: step=%0d tone=%b, required 1 0", step_idx, tone_en);
    end
    adv();
    tests++;
    if (note_sel !== 4'd4 || tone_en !== 1'b1) begin
      errors++;
      $display("FAIL step1_play: note=%0d tone=%b, required 4 1", note_sel, tone_en);
    end
    // Finish the pass to return to IDLE.
    run_to(118);
  endtask

  task automatic test_full_pass();
    loop_en = 1'b0;
    pulse_start();
    while (t <= 116) begin
      chk_pass("full_pass", t);
      adv();
    end
    tests++;
    if (done !== 1'b1 || busy !== 1'b1 || tone_en !== 1'b0) begin
      errors++;
      $display("FAIL finish_t117: done=%b busy=%b tone=%b, required 1 1 0", done, busy, tone_en);
    end
    adv();
    chk_idle("idle_after_pass");
    adv();
    chk_idle("idle_after_pass_2");
  endtask

  task automatic test_loop();
    int dseen;
    loop_en = 1'b1;
    pulse_start();
    while (t <= 116) begin
      chk_pass("loop_pass1", t);
      adv();
    end
    tests++;
    if (step_idx !== 8'd0 || busy !== 1'b1 || done !== 1'b0 || tone_en !== 1'b0) begin
      errors++;
      $display("FAIL loop_wrap: step=%0d busy=%b done=%b tone=%b, required 0 1 0 0",
               step_idx, busy, done, tone_en);
    end
    dseen = 0;
    while (t < 234) begin
      adv();
      if (t == 120) loop_en = 1'b0;
      if (t < 234 && done === 1'b1) dseen++;
      if (t < 234 && t >= 117 && t <= 233) begin
        if (t - 117 == 48) chk_pass("loop_pass2", t - 117);
      end
    end
    tests++;
    if (dseen != 0 || done !== 1'b1) begin
      errors++;
      $display("FAIL loop_done: early_done=%0d done_at_234=%b, required 0 1", dseen, done);
    end
    adv();
    chk_idle("idle_after_loop");
  endtask

  task automatic test_stop();
    int dseen;
    pulse_start();
    run_to(36);
    chk_pass("stop_pre", t);
    stop = 1'b1;
    adv();
    stop = 1'b0;
    chk_idle("stop_idle");
    dseen = 0;
    repeat (130) begin
      adv();
      if (done !== 1'b0 || busy !== 1'b0) dseen++;
    end
    tests++;
    if (dseen != 0) begin
      errors++;
      $display("FAIL stop_no_done: %0d cycles with busy/done set, required 0", dseen);
    end
  endtask

  task automatic test_start_busy();
    pulse_start();
    run_to(16);
    start = 1'b1; adv(); start = 1'b0; adv();
    start = 1'b1; adv(); start = 1'b0;
    run_to(20);
    chk_pass("busy_start_t20", t);
    run_to(24);
    chk_pass("busy_start_t24", t);
    run_to(25);
    chk_pass("busy_start_t25", t);
    run_to(117);
    tests++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL busy_start_done: done=%b at t=117, required 1", done);
    end
    adv();
    start = 1'b1; stop = 1'b1;
    adv();
    start = 1'b0; stop = 1'b0;
    chk_idle("start_stop_idle");
    adv();
    chk_idle("start_stop_idle_2");
  endtask

  task automatic test_async_reset();
    pulse_start();
    run_to(62);
    chk_pass("pre_reset_step12", t);
    #2 rst_n = 1'b0;
    #1 chk_idle("async_reset");
    @(negedge clk);
    chk_idle("async_reset_held");
    rst_n = 1'b1;
    pulse_start();
    tests++;
    if (busy !== 1'b1 || step_idx !== 8'd0) begin
      errors++;
      $display("FAIL replay_load: busy=%b step=%0d, required 1 0", busy, step_idx);
    end
    while (t <= 30) begin
      chk_pass("replay", t);
      adv();
    end
    run_to(118);
    chk_idle("replay_end");
  endtask

  initial begin
    test_reset();
    test_first_step();
    test_full_pass();
    test_loop();
    test_stop();
    test_start_busy();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
